// File: rtl/cd_config_multi.sv
// cd_config_multi: per-channel clock-divider tick generator with a shared
// configuration bus. New divider limits are parked in a shadow register and
// only become active at the channel's counter wrap (or immediately while the
// channel is disabled), so a running tick period is never cut short.
`timescale 1ns/1ps
module cd_config_multi #(
  parameter int NUM_CH            = 2,
  parameter int WIDTH_CONFIG_ADDR = 4,
  parameter int WIDTH_LIMIT       = 16,
  parameter logic [NUM_CH*WIDTH_LIMIT-1:0] DEFAULT_LIMITS = {16'd5208, 16'd2}
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH_CONFIG_ADDR-1:0]  c_addr,
  input  logic [WIDTH_LIMIT-1:0]        c_data,
  input  logic                          c_valid,
  output logic [NUM_CH-1:0]             c_ready,
  output logic                          c_error,
  input  logic [NUM_CH-1:0]             ch_en,
  output logic [NUM_CH-1:0]             tick,
  output logic [NUM_CH*WIDTH_LIMIT-1:0] limit
);

  localparam logic [WIDTH_LIMIT-1:0] MIN_LIMIT = WIDTH_LIMIT'(2);
  localparam logic [WIDTH_LIMIT-1:0] ONE       = WIDTH_LIMIT'(1);

  logic [WIDTH_LIMIT-1:0] active_q [NUM_CH];
  logic [WIDTH_LIMIT-1:0] active_d [NUM_CH];
  logic [WIDTH_LIMIT-1:0] shadow_q [NUM_CH];
  logic [WIDTH_LIMIT-1:0] shadow_d [NUM_CH];
  logic [WIDTH_LIMIT-1:0] cnt_q    [NUM_CH];
  logic [WIDTH_LIMIT-1:0] cnt_d    [NUM_CH];
  logic [NUM_CH-1:0]      pending_q, pending_d;
  logic [NUM_CH-1:0]      tick_q, tick_d;
  logic [NUM_CH-1:0]      sel;
  logic [NUM_CH-1:0]      wrap;
  logic                   accept;
  logic                   error_q, error_d;

  // Address decode: address k selects channel k-1; 0 and out-of-range select nothing
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel[i] = (c_addr == WIDTH_CONFIG_ADDR'(i + 1));
    end
  end

  // A request is taken only for a real, idle channel with a usable limit
  assign accept  = c_valid && (|(sel & ~pending_q)) && (c_data >= MIN_LIMIT);
  assign error_d = c_valid && !accept;

  // Per-channel next state: count, wrap/tick, shadow apply and request capture
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      active_d[i]  = active_q[i];
      shadow_d[i]  = shadow_q[i];
      cnt_d[i]     = cnt_q[i];
      pending_d[i] = pending_q[i];
      tick_d[i]    = 1'b0;
      wrap[i]      = (cnt_q[i] == (active_q[i] - ONE));

      if (!ch_en[i]) begin
        cnt_d[i] = '0;
        if (pending_q[i]) begin
          active_d[i]  = shadow_q[i];
          pending_d[i] = 1'b0;
        end
      end else if (wrap[i]) begin
        cnt_d[i]  = '0;
        tick_d[i] = 1'b1;
        if (pending_q[i]) begin
          active_d[i]  = shadow_q[i];
          pending_d[i] = 1'b0;
        end
      end else begin
        cnt_d[i] = cnt_q[i] + ONE;
      end

      // Accept only happens when pending_q is clear, so it never collides with an apply
      if (accept && sel[i]) begin
        shadow_d[i]  = c_data;
        pending_d[i] = 1'b1;
      end
    end
  end

  // State registers; reset restores the default limits and drops any pending update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        active_q[i] <= DEFAULT_LIMITS[i*WIDTH_LIMIT +: WIDTH_LIMIT];
        shadow_q[i] <= DEFAULT_LIMITS[i*WIDTH_LIMIT +: WIDTH_LIMIT];
        cnt_q[i]    <= '0;
      end
      pending_q <= '0;
      tick_q    <= '0;
      error_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        active_q[i] <= active_d[i];
        shadow_q[i] <= shadow_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      pending_q <= pending_d;
      tick_q    <= tick_d;
      error_q   <= error_d;
    end
  end

  // Pack the active limits for the downstream cores, channel 0 in the LSBs
  always_comb begin
    limit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      limit[i*WIDTH_LIMIT +: WIDTH_LIMIT] = active_q[i];
    end
  end

  assign c_ready = ~pending_q;
  assign c_error = error_q;
  assign tick    = tick_q;

endmodule

// File: doc/cd_config_multi.md
Name: cd_config_multi

Overview:
- Parametrised clock-divider configuration and tick generator for NUM_CH independent channels, such as UART baud and VGA pixel.
- Each channel has its own divider limit, written through the shared config bus (c_addr/c_data/c_valid).
- A new limit is held in a shadow register and applied only at the channel's counter wrap, so tick periods never glitch.
- Sits between the config slave and the UART/VGA cores, which consume tick[] and limit[].

Parameters:
- NUM_CH, 2, number of divider channels (1..15).
- WIDTH_CONFIG_ADDR, 4, config address width; must satisfy 2^WIDTH_CONFIG_ADDR > NUM_CH.
- WIDTH_LIMIT, 16, divider limit and counter width.
- DEFAULT_LIMITS, {16'd5208, 16'd2}, packed NUM_CH*WIDTH_LIMIT reset limits; channel 0 is in the LSBs.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- c_addr  in  WIDTH_CONFIG_ADDR  address; value k (1..NUM_CH) selects channel k-1; 0 and >NUM_CH are invalid.
- c_data  in  WIDTH_LIMIT  requested divider limit (tick period in clk cycles).
- c_valid  in  1  config request strobe.
- c_ready  out  NUM_CH  per-channel ready; 1 = no pending update.
- c_error  out  1  one-cycle pulse when a request is rejected.
- ch_en  in  NUM_CH  per-channel counter enable.
- tick  out  NUM_CH  one-cycle pulse per divider period.
- limit  out  NUM_CH*WIDTH_LIMIT  packed active limit per channel.

Behaviour:
- Per-channel state: active (WIDTH_LIMIT), shadow (WIDTH_LIMIT), pending (1), cnt (WIDTH_LIMIT), tick register.
- Reset values: active = DEFAULT_LIMITS slice, shadow = same, pending = 0, cnt = 0, tick = 0, c_ready = all 1s, c_error = 0.
- c_ready[i] = ~pending[i]. It is registered through pending, so no combinational path from c_valid.
- Request accepted when all of the following hold:
  - c_valid = 1.
  - 1 <= c_addr <= NUM_CH.
  - c_ready[c_addr-1] = 1.
  - c_data >= 2.
- On accept, at the next edge: shadow <= c_data, pending <= 1, so c_ready for that channel drops the following cycle.
- Rejections: c_valid with an invalid address, a not-ready channel, or c_data < 2 has no state change; c_error = 1 for exactly the next cycle.
- c_valid = 0 means c_error = 0 next cycle.
- Counter, enabled channel:
  - cnt increments each cycle.
  - When cnt == active-1 (wrap): cnt <= 0 and tick <= 1 next cycle, otherwise tick <= 0.
  - Tick period = active cycles. The first tick after reset release appears at the active-th rising edge.
- Apply: on a wrap with pending = 1, active <= shadow and pending <= 0.
  - limit[] and the new period take effect from that wrap.
  - c_ready returns to 1 the cycle after the wrap.
- Disabled channel (ch_en[i] = 0):
  - cnt <= 0, tick <= 0.
  - If pending, active <= shadow and pending <= 0 on the next edge, i.e. immediate apply.
- Simultaneous accept and wrap on one channel: the wrap sees the old pending (0), so no apply. The new value applies at the following wrap.
- Wrap with no pending: active is unchanged.
- ch_en falling mid-count: cnt clears next cycle and no tick is emitted. ch_en rising: counting restarts from 0.
- Only one request per cycle (single bus); channels are otherwise fully independent.
- rst asserted mid-operation: all state returns to reset values immediately (asynchronous); a pending shadow value is discarded.
- Arithmetic: cnt compare is unsigned at WIDTH_LIMIT bits. No overflow is possible since active >= 2.

Test Plan:
- Reset/default: NUM_CH=2, WIDTH_LIMIT=8, DEFAULT_LIMITS={8'd4,8'd10}, ch_en=2'b11.
  - Required: tick[0] every 10 cycles, first at edge 10; tick[1] every 4 cycles.
  - limit=16'h040A; c_ready=2'b11; c_error=0.
- Glitch-free update: write addr=1, data=6 while channel 0 cnt=3.
  - c_ready[0]=0 the cycle after accept.
  - The current period still completes at 10 cycles, then periods are 6.
  - limit[7:0]=6 from that wrap; c_ready[0]=1 the cycle after the wrap.
- Rejections (c_error single pulse each, no state change):
  - addr=0, data=5.
  - addr=3, data=5.
  - addr=2, data=1.
  - A second write to addr=1 while pending.
- Disabled apply: ch_en[1]=0, write addr=2, data=7.
  - Required: tick[1] stays 0; limit[15:8]=7 and c_ready[1]=1 two cycles after accept.
  - After re-enabling, first tick[1] after 7 cycles.
- Simultaneous accept and wrap: write addr=1, data=3 in the cycle cnt[0]=active-1.
  - Required: the next period keeps the old limit; period 3 starts only at the following wrap.
- Reset mid-pending: accept addr=1, data=20, then assert rst before the wrap.
  - Required: limit[7:0] returns to 10, c_ready=2'b11, and 20 never takes effect.
